// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline control unit. It merges per-stage stall requests,
//             load-use hazards, WFI and fetch/decode exceptions. It drives the
//             stall vector, flush, the trap redirect and the host-visible
//             status and exception registers.
//  Options  : PIPE_CTRL_PERF_EN adds the perf_stall_cycles counter output.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
   parameter int                STAGES    = 6,
   parameter int                ADDR_W    = 32,
   parameter int                FLUSH_CYC = 2,
   parameter logic [ADDR_W-1:0] TRAP_VEC  = 32'h0000_0100,
   parameter int                ID_STAGE  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_pc,
   input  logic [2:0]        core_configuration,
   input  logic [STAGES-1:0] stallreq,
   input  logic              is_loadrelated,
   input  logic              is_wfi,
   input  logic              irq_pending,
   input  logic              pc_invalid,
   input  logic              inst_invalid,
   input  logic [ADDR_W-1:0] exc_pc_in,
   output logic [STAGES-1:0] stall,
   output logic              flush,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [2:0]        core_status,
   output logic [1:0]        core_exception,
   output logic [ADDR_W-1:0] core_exception_pc
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_WFI  = 3'd2,
      ST_EXC  = 3'd3,
      ST_HALT = 3'd4
   } state_t;

   // Counter holds the number of flush cycles still to come after the current one.
   localparam int                 c_cnt_w    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(FLUSH_CYC - 1);

   state_t              r_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic                r_redirect_valid;
   logic [ADDR_W-1:0]   r_redirect_pc;
   logic [1:0]          r_cause;
   logic [ADDR_W-1:0]   r_exc_pc;

   logic                w_pc_exc;
   logic                w_ill_exc;
   logic [STAGES-1:0]   w_run_stall;
   logic [STAGES-1:0]   w_wfi_stall;
   logic [STAGES-1:0]   w_stall;

   assign w_pc_exc  = pc_invalid   & ~core_configuration[0];
   assign w_ill_exc = inst_invalid & ~core_configuration[1];

   // RUN stall: thermometer below the highest requesting stage, OR'd with hazard masks.
   always_comb begin
      logic v_acc;
      v_acc       = 1'b0;
      w_run_stall = '0;
      w_wfi_stall = '0;
      for (int j = STAGES - 1; j >= 0; j--) begin
         v_acc          = v_acc | stallreq[j];
         w_wfi_stall[j] = (j <= ID_STAGE);
         w_run_stall[j] = v_acc
                        | ((j <= ID_STAGE)     & (is_loadrelated | is_wfi | w_ill_exc))
                        | ((j <= ID_STAGE + 1) & w_pc_exc);
      end
   end

   // Stall selection by state; only RUN passes the live input terms through.
   always_comb begin
      case (r_state)
         ST_RUN:  w_stall = w_run_stall;
         ST_WFI:  w_stall = w_wfi_stall;
         default: w_stall = '1;
      endcase
   end

   // Control FSM with flush counter, one-shot redirect and sticky exception capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_cnt            <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_cause          <= 2'd0;
         r_exc_pc         <= '0;
      end else begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         case (r_state)
            ST_IDLE: begin
               if (start_pc) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_ill_exc | w_pc_exc) begin
                  // First fault wins; later faults still flush but keep the record.
                  if (r_cause == 2'd0) begin
                     r_cause  <= w_ill_exc ? 2'd2 : 2'd1;
                     r_exc_pc <= exc_pc_in;
                  end
                  r_cnt   <= c_cnt_load;
                  r_state <= ST_EXC;
               end else if (is_wfi) begin
                  r_state <= ST_WFI;
               end
            end
            ST_WFI: begin
               if (irq_pending) r_state <= ST_RUN;
            end
            ST_EXC: begin
               if (r_cnt == '0) begin
                  if (core_configuration[2]) begin
                     r_state <= ST_HALT;
                  end else begin
                     r_redirect_valid <= 1'b1;
                     r_redirect_pc    <= TRAP_VEC;
                     r_state          <= ST_RUN;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_HALT: begin
               if (start_pc) begin
                  r_cause  <= 2'd0;
                  r_exc_pc <= '0;
                  r_state  <= ST_RUN;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_perf;

   // Count stalled cycles while the core is live (RUN or WFI); wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf <= '0;
      end else if (((r_state == ST_RUN) || (r_state == ST_WFI)) && w_stall[0]) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_stall_cycles = r_perf;
`endif

   assign stall             = w_stall;
   assign flush             = (r_state == ST_EXC);
   assign redirect_valid    = r_redirect_valid;
   assign redirect_pc       = r_redirect_pc;
   assign core_status       = r_state;
   assign core_exception    = r_cause;
   assign core_exception_pc = r_exc_pc;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Self-checking bench for pipe_ctrl: directed scenarios followed
//             by randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

   localparam int          STAGES    = 6;
   localparam int          ADDR_W    = 32;
   localparam int          FLUSH_CYC = 2;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
   localparam int          ID_STAGE  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_pc = 1'b0;
   logic [2:0]        core_configuration = 3'b000;
   logic [STAGES-1:0] stallreq = '0;
   logic              is_loadrelated = 1'b0;
   logic              is_wfi = 1'b0;
   logic              irq_pending = 1'b0;
   logic              pc_invalid = 1'b0;
   logic              inst_invalid = 1'b0;
   logic [ADDR_W-1:0] exc_pc_in = '0;
   logic [STAGES-1:0] stall;
   logic              flush;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic [2:0]        core_status;
   logic [1:0]        core_exception;
   logic [ADDR_W-1:0] core_exception_pc;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]       perf_stall_cycles;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   pipe_ctrl #(
      .STAGES(STAGES), .ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC),
      .TRAP_VEC(TRAP_VEC), .ID_STAGE(ID_STAGE)
   ) dut (
      .clk(clk), .rst(rst), .start_pc(start_pc),
      .core_configuration(core_configuration), .stallreq(stallreq),
      .is_loadrelated(is_loadrelated), .is_wfi(is_wfi), .irq_pending(irq_pending),
      .pc_invalid(pc_invalid), .inst_invalid(inst_invalid), .exc_pc_in(exc_pc_in),
      .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .core_status(core_status),
      .core_exception(core_exception), .core_exception_pc(core_exception_pc)
`ifdef PIPE_CTRL_PERF_EN
      , .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start_pc = 0; stallreq = '0; is_loadrelated = 0; is_wfi = 0;
      irq_pending = 0; pc_invalid = 0; inst_invalid = 0;
   endtask

   task automatic do_reset_start();
      clear_inputs(); core_configuration = 3'b000;
      rst = 1; tick(); tick(); rst = 0;
      start_pc = 1; tick(); start_pc = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1; tick(); tick(); #1;
      n_tests++; if (stall !== 6'h3F) begin n_fail++; $display("FAIL reset_stall: got %h expected 3f", stall); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", flush); end
      n_tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect: got %b/%h expected 0/0", redirect_valid, redirect_pc); end
      n_tests++; if (core_status !== 3'd0) begin n_fail++; $display("FAIL reset_status: got %0d expected 0", core_status); end
      n_tests++; if (core_exception !== 2'd0 || core_exception_pc !== 32'h0) begin n_fail++; $display("FAIL reset_exc: got %0d/%h expected 0/0", core_exception, core_exception_pc); end
`ifdef PIPE_CTRL_PERF_EN
      n_tests++; if (perf_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d expected 0", perf_stall_cycles); end
`endif
      rst = 0;
      stallreq = 6'h3F; pc_invalid = 1; tick(); tick();
      n_tests++; if (core_status !== 3'd0) begin n_fail++; $display("FAIL idle_ignore: got %0d expected 0", core_status); end
      clear_inputs();
   endtask

   task automatic test_stall_run();
      start_pc = 1; tick(); start_pc = 0;
      n_tests++; if (core_status !== 3'd1) begin n_fail++; $display("FAIL run_status: got %0d expected 1", core_status); end
      stallreq = 6'b000100; #1;
      n_tests++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL run_stall_k2: got %b expected 000111", stall); end
      stallreq = 6'b100010; #1;
      n_tests++; if (stall !== 6'b111111) begin n_fail++; $display("FAIL run_stall_k5: got %b expected 111111", stall); end
      stallreq = 6'b000000; #1;
      n_tests++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL run_stall_none: got %b expected 000000", stall); end
      is_loadrelated = 1; #1;
      n_tests++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL run_stall_ld: got %b expected 000111", stall); end
      is_loadrelated = 0;
   endtask

   task automatic test_trap();
      core_configuration = 3'b000;
      inst_invalid = 1; exc_pc_in = 32'h40; #1;
      n_tests++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL trap_detect_stall: got %b expected 000111", stall); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL trap_detect_flush: got %b expected 0", flush); end
      tick(); clear_inputs();
      n_tests++; if (flush !== 1'b1 || stall !== 6'h3F) begin n_fail++; $display("FAIL trap_flush1: got %b/%h expected 1/3f", flush, stall); end
      n_tests++; if (core_exception !== 2'd2 || core_exception_pc !== 32'h40) begin n_fail++; $display("FAIL trap_cause: got %0d/%h expected 2/40", core_exception, core_exception_pc); end
      tick();
      n_tests++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL trap_flush2: got %b/%b expected 1/0", flush, redirect_valid); end
      tick();
      n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100 || core_status !== 3'd1 || flush !== 1'b0) begin n_fail++; $display("FAIL trap_redirect: got %b/%h/%0d/%b expected 1/100/1/0", redirect_valid, redirect_pc, core_status, flush); end
      tick();
      n_tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL trap_pulse_end: got %b/%h expected 0/0", redirect_valid, redirect_pc); end
      // Second fault while a cause is recorded must not overwrite it.
      pc_invalid = 1; exc_pc_in = 32'h80; tick(); clear_inputs();
      n_tests++; if (core_status !== 3'd3 || core_exception !== 2'd2 || core_exception_pc !== 32'h40) begin n_fail++; $display("FAIL trap_sticky: got %0d/%0d/%h expected 3/2/40", core_status, core_exception, core_exception_pc); end
      tick(); tick(); tick();
   endtask

   task automatic test_halt();
      do_reset_start();
      core_configuration = 3'b101;
      pc_invalid = 1; inst_invalid = 1; exc_pc_in = 32'h44; tick(); clear_inputs();
      n_tests++; if (core_exception !== 2'd2 || core_exception_pc !== 32'h44) begin n_fail++; $display("FAIL halt_cause: got %0d/%h expected 2/44", core_exception, core_exception_pc); end
      tick(); tick();
      n_tests++; if (core_status !== 3'd4 || flush !== 1'b0 || stall !== 6'h3F || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got %0d/%b/%h/%b expected 4/0/3f/0", core_status, flush, stall, redirect_valid); end
      pc_invalid = 1; inst_invalid = 1; exc_pc_in = 32'h99; tick(); clear_inputs();
      n_tests++; if (core_status !== 3'd4 || core_exception_pc !== 32'h44) begin n_fail++; $display("FAIL halt_second: got %0d/%h expected 4/44", core_status, core_exception_pc); end
      start_pc = 1; tick(); start_pc = 0;
      n_tests++; if (core_status !== 3'd1 || core_exception !== 2'd0 || core_exception_pc !== 32'h0) begin n_fail++; $display("FAIL halt_restart: got %0d/%0d/%h expected 1/0/0", core_status, core_exception, core_exception_pc); end
      core_configuration = 3'b000;
   endtask

   task automatic test_mask();
      core_configuration = 3'b001; pc_invalid = 1; #1;
      n_tests++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL mask_stall: got %b expected 000000", stall); end
      tick();
      n_tests++; if (core_status !== 3'd1 || core_exception !== 2'd0) begin n_fail++; $display("FAIL mask_noexc: got %0d/%0d expected 1/0", core_status, core_exception); end
      pc_invalid = 0; core_configuration = 3'b010; inst_invalid = 1; #1;
      n_tests++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL mask_ill_stall: got %b expected 000000", stall); end
      tick(); clear_inputs(); core_configuration = 3'b000;
      n_tests++; if (core_status !== 3'd1) begin n_fail++; $display("FAIL mask_ill_noexc: got %0d expected 1", core_status); end
   endtask

   task automatic test_wfi();
      is_wfi = 1; tick(); is_wfi = 0;
      n_tests++; if (core_status !== 3'd2) begin n_fail++; $display("FAIL wfi_enter: got %0d expected 2", core_status); end
      for (int i = 0; i < 10; i++) begin
         stallreq = 6'h20; inst_invalid = 1; pc_invalid = 1; #1;
         n_tests++; if (stall !== 6'b000111 || core_status !== 3'd2 || flush !== 1'b0) begin n_fail++; $display("FAIL wfi_hold[%0d]: got %b/%0d/%b expected 000111/2/0", i, stall, core_status, flush); end
         tick();
      end
      clear_inputs(); irq_pending = 1; tick(); irq_pending = 0; #1;
      n_tests++; if (core_status !== 3'd1 || stall !== 6'b000000 || core_exception !== 2'd0) begin n_fail++; $display("FAIL wfi_wake: got %0d/%b/%0d expected 1/000000/0", core_status, stall, core_exception); end
   endtask

   task automatic test_reset_mid_exc();
      do_reset_start();
      inst_invalid = 1; exc_pc_in = 32'h50; tick(); clear_inputs();
      tick();
      n_tests++; if (flush !== 1'b1 || core_status !== 3'd3) begin n_fail++; $display("FAIL midexc_pre: got %b/%0d expected 1/3", flush, core_status); end
      rst = 1; tick(); rst = 0;
      n_tests++; if (core_status !== 3'd0 || flush !== 1'b0 || redirect_valid !== 1'b0 || core_exception !== 2'd0) begin n_fail++; $display("FAIL midexc_reset: got %0d/%b/%b/%0d expected 0/0/0/0", core_status, flush, redirect_valid, core_exception); end
      tick();
      n_tests++; if (redirect_valid !== 1'b0 || core_status !== 3'd0) begin n_fail++; $display("FAIL midexc_nopulse: got %b/%0d expected 0/0", redirect_valid, core_status); end
`ifdef PIPE_CTRL_PERF_EN
      n_tests++; if (perf_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL midexc_perf: got %0d expected 0", perf_stall_cycles); end
`endif
   endtask

   // Expected stall vector from the rules, by arithmetic on the highest request index.
   function automatic logic [5:0] model_stall(int st, logic [5:0] req, logic ld, logic wfi,
                                              logic ill, logic pce);
      int k;
      int v;
      if (st == 1) begin
         k = -1;
         for (int i = 0; i < STAGES; i++) if (req[i]) k = i;
         v = (k >= 0) ? (2 ** (k + 1)) - 1 : 0;
         if (ld || wfi || ill) v = v | ((2 ** (ID_STAGE + 1)) - 1);
         if (pce)              v = v | ((2 ** (ID_STAGE + 2)) - 1);
         return 6'(v);
      end else if (st == 2) begin
         return 6'((2 ** (ID_STAGE + 1)) - 1);
      end
      return 6'h3F;
   endfunction

   task automatic test_random();
      int          m_st, m_left, m_cause;
      logic        m_redir;
      logic [31:0] m_epc, m_perf;
      logic [5:0]  e_stall;
      logic        ill, pce;
      clear_inputs(); rst = 1; tick(); rst = 0;
      m_st = 0; m_left = 0; m_cause = 0; m_redir = 0; m_epc = 0; m_perf = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst                = ($urandom_range(0, 79) == 0);
         start_pc           = ($urandom_range(0, 5) == 0);
         core_configuration = ($urandom_range(0, 3) == 0) ? 3'($urandom) : core_configuration;
         stallreq           = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
         is_loadrelated     = ($urandom_range(0, 4) == 0);
         is_wfi             = ($urandom_range(0, 9) == 0);
         irq_pending        = ($urandom_range(0, 3) == 0);
         pc_invalid         = ($urandom_range(0, 11) == 0);
         inst_invalid       = ($urandom_range(0, 11) == 0);
         exc_pc_in          = $urandom;
         #1;
         ill = inst_invalid & ~core_configuration[1];
         pce = pc_invalid & ~core_configuration[0];
         e_stall = model_stall(m_st, stallreq, is_loadrelated, is_wfi, ill, pce);
         n_tests++; if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall@%0d: got %b expected %b", cyc, stall, e_stall); end
         n_tests++; if (flush !== (m_st == 3)) begin n_fail++; $display("FAIL rnd_flush@%0d: got %b expected %b", cyc, flush, m_st == 3); end
         n_tests++; if (core_status !== 3'(m_st)) begin n_fail++; $display("FAIL rnd_status@%0d: got %0d expected %0d", cyc, core_status, m_st); end
         n_tests++; if (redirect_valid !== m_redir || redirect_pc !== (m_redir ? TRAP_VEC : 32'h0)) begin n_fail++; $display("FAIL rnd_redirect@%0d: got %b/%h expected %b", cyc, redirect_valid, redirect_pc, m_redir); end
         n_tests++; if (core_exception !== 2'(m_cause) || core_exception_pc !== m_epc) begin n_fail++; $display("FAIL rnd_exc@%0d: got %0d/%h expected %0d/%h", cyc, core_exception, core_exception_pc, m_cause, m_epc); end
`ifdef PIPE_CTRL_PERF_EN
         n_tests++; if (perf_stall_cycles !== m_perf) begin n_fail++; $display("FAIL rnd_perf@%0d: got %0d expected %0d", cyc, perf_stall_cycles, m_perf); end
`endif
         // Advance the model by one clock.
         if (rst) begin
            m_st = 0; m_left = 0; m_cause = 0; m_redir = 0; m_epc = 0; m_perf = 0;
         end else begin
            if ((m_st == 1 || m_st == 2) && e_stall[0]) m_perf = m_perf + 32'd1;
            m_redir = 0;
            case (m_st)
               0: if (start_pc) m_st = 1;
               1: begin
                  if (ill || pce) begin
                     if (m_cause == 0) begin m_cause = ill ? 2 : 1; m_epc = exc_pc_in; end
                     m_left = FLUSH_CYC; m_st = 3;
                  end else if (is_wfi) m_st = 2;
               end
               2: if (irq_pending) m_st = 1;
               3: begin
                  m_left--;
                  if (m_left == 0) begin
                     if (core_configuration[2]) m_st = 4;
                     else begin m_st = 1; m_redir = 1; end
                  end
               end
               default: if (start_pc) begin m_st = 1; m_cause = 0; m_epc = 0; end
            endcase
         end
         tick();
      end
      clear_inputs(); rst = 0; core_configuration = 3'b000;
   endtask

   initial begin
      test_reset();
      test_stall_run();
      test_trap();
      test_halt();
      test_mask();
      test_wfi();
      test_reset_mid_exc();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the core. Collects per-stage stall requests, load-use hazards, WFI and fetch/decode exceptions.
- Drives the per-stage stall vector, flush, trap redirect, and the registered core status/exception registers seen by the host.
- Sits beside the pipeline. The stall/flush outputs feed every pipeline register, and redirect feeds the pc register.

Parameters:
- STAGES, 6, stall-vector width; bit 0 = pc, bit i = pipeline register i.
- ADDR_W, 32, pc/exception-pc width.
- FLUSH_CYC, 2, cycles flush is held after an exception is taken (>=1).
- TRAP_VEC, 32'h0000_0100, redirect target after an exception.
- ID_STAGE, 2, highest stall bit set for load-use/WFI/illegal-instruction (stall bits 0..ID_STAGE).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_pc  in  1  one-cycle pulse; leaves IDLE.
- core_configuration  in  3  [0] mask pc-unaligned, [1] mask illegal-inst, [2] halt on exception (else trap).
- stallreq  in  STAGES  bit i = stage i requests stall.
- is_loadrelated  in  1  load-use hazard in decode.
- is_wfi  in  1  WFI decoded.
- irq_pending  in  1  wake source for WFI.
- pc_invalid  in  1  fetch pc unaligned.
- inst_invalid  in  1  decode illegal instruction.
- exc_pc_in  in  ADDR_W  pc of the faulting instruction.
- stall  out  STAGES  per-stage hold.
- flush  out  1  kill all in-flight instructions.
- redirect_valid  out  1  one-cycle pulse; pc loads redirect_pc.
- redirect_pc  out  ADDR_W  equals TRAP_VEC when valid, else 0.
- core_status  out  3  encoded FSM state.
- core_exception  out  2  sticky cause: 0 none, 1 pc-unaligned, 2 illegal-inst.
- core_exception_pc  out  ADDR_W  pc captured at the exception.

Behaviour:
- FSM states and core_status codes: IDLE=0, RUN=1, WFI=2, EXC=3, HALT=4. Reset enters IDLE.
- Reset values: stall=all ones, flush=0, redirect_valid=0, redirect_pc=0, core_exception=0, core_exception_pc=0, counter=0.
- Exception qualification (combinational): pc_exc = pc_invalid & ~cfg[0]; ill_exc = inst_invalid & ~cfg[1].
- IDLE:
  - stall=all ones.
  - start_pc -> RUN next cycle.
  - Any other inputs are ignored.
- RUN, stall is combinational from the current inputs:
  - k = highest set index of stallreq; stall[j]=1 for all j<=k.
  - is_loadrelated or is_wfi or ill_exc additionally forces stall bits 0..ID_STAGE.
  - pc_exc forces bits 0..ID_STAGE+1.
  - The result is the OR of all terms.
- RUN, exception priority: ill_exc over pc_exc; an exception beats WFI.
  - On an exception: register the cause and exc_pc_in, load counter=FLUSH_CYC-1, go to EXC.
  - Else on is_wfi: go to WFI.
- Exception capture:
  - A cause is captured only while core_exception==0 (first fault wins).
  - The cause is cleared only by rst or by start_pc while in HALT.
- EXC:
  - flush=1, stall=all ones.
  - Counter decrements each cycle. Flush asserts from the cycle after detection and lasts exactly FLUSH_CYC cycles.
  - At counter==0:
    - if cfg[2]: go to HALT;
    - else: assert redirect_valid=1 with redirect_pc=TRAP_VEC for one cycle (the cycle after the last flush cycle, with state RUN, flush=0), and continue in RUN.
- WFI:
  - stall bits 0..ID_STAGE held; flush=0.
  - irq_pending -> RUN next cycle.
  - An exception input while in WFI is ignored.
- HALT:
  - stall=all ones, flush=0.
  - start_pc clears core_exception/core_exception_pc and goes to RUN.
- rst asserted in any state (including mid-EXC) wins the next edge: IDLE, counter cleared, any pending redirect dropped.
- stall, flush and redirect change only via FSM/register state or the documented combinational RUN terms. Latency from exception input to flush is 1 cycle.

Optional Feature:
- PIPE_CTRL_PERF_EN defined:
  - Adds output perf_stall_cycles [31:0].
  - Counts cycles in RUN or WFI with stall[0]==1.
  - Wraps at 2^32, resets to 0 on rst, frozen in IDLE/HALT.
- Undefined: port absent, no counter logic.

Test Plan:
- rst then start_pc, stallreq=6'b000100 -> stall=6'b000111, core_status=1; stallreq=0 -> stall=0.
- In RUN, inst_invalid=1, cfg=3'b000, exc_pc_in=32'h40 -> next 2 cycles flush=1, stall=6'h3F, core_exception=2, core_exception_pc=32'h40; then one cycle of redirect_valid=1, redirect_pc=32'h100, core_status=1.
- cfg=3'b101, pc_invalid=1 same cycle as inst_invalid=1 -> cause=2 (illegal wins); after flush core_status=4. A second fault leaves the captured pc unchanged. start_pc -> core_exception=0, RUN.
- cfg[0]=1, pc_invalid=1 -> no exception, stall=0, core_exception stays 0.
- is_wfi=1 -> core_status=2, stall=6'b000111 held for 10 cycles; irq_pending=1 -> RUN, stall=0.
- rst asserted during the 2nd EXC cycle -> next cycle core_status=0, flush=0, no redirect pulse. With PIPE_CTRL_PERF_EN, perf_stall_cycles=0.
